// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit a + b + cin split into STAGES registered
// ripple slices with global valid/ready stall. Define PIPE_ADD_SUB_EN to add a 'sub' input.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PIPE_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int S = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             adv;

`ifdef PIPE_ADD_SUB_EN
  // Subtraction as a + ~b + 1; carry-out then reads as "no borrow".
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  // One global stall: the whole pipe moves only when the output slot frees up.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k * S;   // operand bits still to be summed
    localparam int RW = (k + 1) * S;     // result bits produced so far

    logic [IW-1:0] ain, bin;
    logic          cin_s, vin;
    logic [S-1:0]  slice;
    logic          cout;
    logic [RW-1:0] r_new, r_q, r_d;
    logic          c_q, c_d, v_q, v_d;

    if (k == 0) begin : g_src
      assign ain   = a;
      assign bin   = b_in;
      assign cin_s = c_in;
      assign vin   = in_valid;
      assign r_new = slice;
    end else begin : g_src
      assign ain   = g_st[k-1].g_op.a_q;
      assign bin   = g_st[k-1].g_op.b_q;
      assign cin_s = g_st[k-1].c_q;
      assign vin   = g_st[k-1].v_q;
      assign r_new = {slice, g_st[k-1].r_q};
    end

    always_comb begin
      logic c;
      c     = cin_s;
      slice = '0;
      for (int i = 0; i < S; i++) begin
        slice[i] = ain[i] ^ bin[i] ^ c;
        c        = (ain[i] & bin[i]) | (c & (ain[i] ^ bin[i]));
      end
      cout = c;
    end

    // Data only loads with a real beat, so the last stage holds sum across bubbles.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      r_d = r_q;
      if (adv) begin
        v_d = vin;
        if (vin) begin
          c_d = cout;
          r_d = r_new;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        r_q <= r_d;
      end
    end

    if (IW > S) begin : g_op
      logic [IW-S-1:0] a_q, a_d, b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv && vin) begin
          a_d = ain[IW-1:S];
          b_d = bin[IW-1:S];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = {g_st[STAGES-1].c_q, g_st[STAGES-1].r_q};

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed table, backpressure/reset sequences,
// and random back-to-back traffic checked against a queue-based a+b+cin model.
module tb_pipelined_ripple_adder;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W:0]   sum;
`ifdef PIPE_ADD_SUB_EN
  logic         sub = 1'b0;
`endif

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PIPE_ADD_SUB_EN
    .sub(sub),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  bit lat_chk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: every accepted beat must come out once, in order, as a+b+cin.
  typedef struct { logic [W:0] exp; int acc_cyc; } sb_t;
  sb_t sbq[$];
  sb_t e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) sbq.delete();
    else begin
      if (out_valid && out_ready) begin
        n_done++;
        if (sbq.size() == 0) chk("unexpected_out", sbq.size(), 1);
        else begin
          e = sbq.pop_front();
          chk("sb_sum", sum, e.exp);
          if (lat_chk) chk("sb_latency", cyc - e.acc_cyc, S);
        end
      end
      if (in_valid && in_ready)
        sbq.push_back('{(W+1)'(a) + (W+1)'(b) + (W+1)'(cin), cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    chk("drain", sbq.size(), 0);
    #1;
  endtask

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic c; logic [W:0] exp; } vec_t;
  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vt[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vt[1] = '{8'h0F, 8'h00, 1'b1, 9'h010};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vt[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vt[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vt[5] = '{8'h7F, 8'h80, 1'b1, 9'h100};
    vt[6] = '{8'hAA, 8'h55, 1'b0, 9'h0FF};

    // Reset held with a beat offered: nothing must be captured.
    rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'h01; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 9'h000);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    d0 = n_done;
    repeat (4) tick();
    chk("rst_nothing_out", n_done - d0, 0);
    chk("rst_ov_idle", out_valid, 0);

    // Directed table: latency 2, then sum holds through the following bubble.
    for (int i = 0; i < 7; i++) begin
      a = vt[i].a; b = vt[i].b; cin = vt[i].c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_early", out_valid, 0);
      @(negedge clk);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_sum", sum, vt[i].exp);
      @(negedge clk);
      chk("tbl_bubble_valid", out_valid, 0);
      chk("tbl_hold_sum", sum, vt[i].exp);
      tick();
    end

    // Back-to-back random traffic at full rate.
    lat_chk = 1'b1;
    d0 = n_done;
    for (int i = 0; i < 256; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", n_done - d0, 256);
    lat_chk = 1'b0;

    // Backpressure: two beats fill the pipe, the third waits.
    d0 = n_done;
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    @(negedge clk); chk("bp_rdy0", in_ready, 1); tick();
    a = 8'h33; b = 8'h44; cin = 1'b1;
    @(negedge clk); chk("bp_rdy1", in_ready, 1); tick();
    a = 8'hF0; b = 8'h20; cin = 1'b1;
    @(negedge clk);
    chk("bp_rdy2", in_ready, 0);
    chk("bp_ov", out_valid, 1);
    chk("bp_sum0", sum, 9'h033);
    tick();
    @(negedge clk);
    chk("bp_hold_sum", sum, 9'h033);
    chk("bp_hold_rdy", in_ready, 0);
    tick();
    out_ready = 1'b1;
    @(negedge clk); chk("bp_release_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();
    chk("bp_count", n_done - d0, 3);

    // Reset with two beats in flight: they must vanish.
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    tick();
    a = 8'h03; b = 8'h04;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ov", out_valid, 0);
    chk("midrst_sum", sum, 9'h000);
    chk("midrst_rdy", in_ready, 1);
    out_ready = 1'b1;
    d0 = n_done;
    repeat (4) tick();
    chk("midrst_flushed", n_done - d0, 0);
    a = 8'h80; b = 8'h80; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk); chk("midrst_early", out_valid, 0);
    @(negedge clk);
    chk("midrst_valid", out_valid, 1);
    chk("midrst_sum80", sum, 9'h100);
    drain();

`ifdef PIPE_ADD_SUB_EN
    sub = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

`ifdef PIPE_ADD_SUB_EN
  // Subtract mode on a 16-bit, 4-stage instance.
  logic        s_rst_n = 1'b0, s_iv = 1'b0, s_sub = 1'b0;
  logic [15:0] s_a = '0, s_b = '0;
  logic        s_ir, s_ov;
  logic [16:0] s_sum;

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(s_rst_n), .sub(s_sub),
    .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b), .cin(1'b0),
    .out_valid(s_ov), .out_ready(1'b1), .sum(s_sum)
  );

  initial begin
    repeat (2) @(posedge clk);
    #1 s_rst_n = 1'b1;
    s_a = 16'h0005; s_b = 16'h0007; s_sub = 1'b1; s_iv = 1'b1;
    @(posedge clk); #1 s_iv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sub_borrow_ov", s_ov, 1);
    chk("sub_borrow", s_sum, 17'h0FFFE);
    @(posedge clk); #1;
    s_a = 16'h0007; s_b = 16'h0005; s_iv = 1'b1;
    @(posedge clk); #1 s_iv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sub_noborrow_ov", s_ov, 1);
    chk("sub_noborrow", s_sum, 17'h10002);
  end
`endif

endmodule
